// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit text controller: command
// bytes, FSM encodings, init ROM and DDRAM row-base lookup.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_NEWLINE  = 8'h0A;

  // Top-level controller states
  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_IDLE, ST_SEND, ST_WAIT, ST_ADDR, ST_CLEAR
  } lcd_state_t;

  // What the transfer currently in flight was, so WAIT knows where to go next
  typedef enum logic [1:0] {
    K_INIT, K_DATA, K_ADDR, K_CLR
  } lcd_kind_t;

  // Nibble transmitter states
  typedef enum logic [2:0] {
    TX_IDLE, TX_SETUP, TX_EHI, TX_GAP, TX_WAIT
  } tx_state_t;

  // Init sequence: entries 0..3 go out as a single (high) nibble, 4..7 as full bytes
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h20;
      3'd4:             return CMD_FUNC_4B2L;
      3'd5:             return CMD_DISP_ON;
      3'd6:             return CMD_CLEAR;
      default:          return CMD_ENTRY_INC;
    endcase
  endfunction

  // DDRAM address of column 0 for a given row; rows 2/3 continue after rows 0/1
  function automatic logic [6:0] row_base(input logic [1:0] row, input int cols);
    logic [6:0] c;
    c = 7'(cols);
    case (row)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return c;
      default: return 7'h40 + c;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one byte (or one lone nibble) onto the 4-bit LCD bus with the
// enable strobe, inter-nibble gap and post-command settle wait.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int E_CYC   = 12,
  parameter int NIB_CYC = 27,
  parameter int CMD_CYC = 1080,
  parameter int CLR_CYC = 44280,
  parameter int PWR_CYC = 405000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_start,
  input  logic       i_nibble_only,
  input  logic       i_long_wait,
  output logic [3:0] o_db,
  output logic       o_e,
  output logic       o_rs,
  output logic       o_done
);

  localparam int CW = $clog2(PWR_CYC + 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(NIB_CYC - 2);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  tx_state_t     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_wait_last;
  logic [3:0]    r_lo_nib;
  logic [3:0]    r_db;
  logic          r_rs, r_lo, r_nib_only, r_long, r_e, r_done;

  // Sequence setup -> E high -> gap -> setup -> E high -> settle wait
  always_comb begin
    w_next      = r_state;
    w_wait_last = r_long ? CLR_LAST : CMD_LAST;
    case (r_state)
      TX_IDLE:  if (i_start) w_next = TX_SETUP;
      TX_SETUP: w_next = TX_EHI;
      TX_EHI:   if (r_cnt == E_LAST) w_next = (r_lo || r_nib_only) ? TX_WAIT : TX_GAP;
      TX_GAP:   if (r_cnt == GAP_LAST) w_next = TX_SETUP;
      TX_WAIT:  if (r_cnt == w_wait_last) w_next = TX_IDLE;
      default:  w_next = TX_IDLE;
    endcase
  end

  // State, saturating timer and registered bus outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= TX_IDLE;
      r_cnt      <= '0;
      r_lo_nib   <= '0;
      r_db       <= '0;
      r_rs       <= 1'b0;
      r_lo       <= 1'b0;
      r_nib_only <= 1'b0;
      r_long     <= 1'b0;
      r_e        <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_e     <= (w_next == TX_EHI);
      r_done  <= (r_state == TX_WAIT) && (w_next == TX_IDLE);
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == TX_IDLE && i_start) begin
        r_db       <= i_byte[7:4];
        r_lo_nib   <= i_byte[3:0];
        r_rs       <= i_rs;
        r_nib_only <= i_nibble_only;
        r_long     <= i_long_wait;
        r_lo       <= 1'b0;
      end
      if (r_state == TX_GAP && w_next == TX_SETUP) begin
        r_db <= r_lo_nib;
        r_lo <= 1'b1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_done = r_done;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: power-up, init, byte stream with cursor
// tracking, line wrap, newline and clear handling.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS    = 2,
  parameter int COLS    = 16,
  parameter int E_CYC   = 12,
  parameter int NIB_CYC = 27,
  parameter int CMD_CYC = 1080,
  parameter int CLR_CYC = 44280,
  parameter int PWR_CYC = 405000
) (
  input  logic       CLK_27,
  input  logic       RESET,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clr_req,
  output logic       clr_ack,
  output logic       init_done,
  output logic [1:0] cur_row,
  output logic [5:0] cur_col,
  output logic [3:0] LCD_FPGA_DB,
  output logic       LCD_FPGA_E,
  output logic       LCD_FPGA_RS,
  output logic       LCD_FPGA_RW
);

  localparam int CW = $clog2(PWR_CYC + 1);
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);

  lcd_state_t    r_state, w_next;
  lcd_kind_t     r_kind;
  logic [CW-1:0] r_pwr_cnt;
  logic [2:0]    r_idx;
  logic [1:0]    r_row, w_next_row;
  logic [5:0]    r_col, w_col_inc;
  logic [7:0]    r_byte, w_tx_byte;
  logic          r_init_done, r_clr_ack;
  logic          w_tx_start, w_tx_rs, w_tx_nib_only, w_tx_long, w_tx_done, w_accept;

  assign char_ready = (r_state == ST_IDLE) && r_init_done && !clr_req;
  assign w_accept   = char_ready && char_valid;
  assign w_next_row = (r_row == 2'(ROWS - 1)) ? 2'd0 : r_row + 2'd1;
  assign w_col_inc  = r_col + 6'd1;
  assign w_tx_long  = !w_tx_rs && (w_tx_byte == CMD_CLEAR || w_tx_byte == CMD_HOME);

  // Next state and the byte handed to the transmitter
  always_comb begin
    w_next        = r_state;
    w_tx_start    = 1'b0;
    w_tx_byte     = r_byte;
    w_tx_rs       = 1'b0;
    w_tx_nib_only = 1'b0;
    case (r_state)
      ST_PWRUP: if (r_pwr_cnt == PWR_LAST) w_next = ST_INIT;
      ST_INIT: begin
        w_tx_start    = 1'b1;
        w_tx_byte     = init_rom(r_idx);
        w_tx_nib_only = !r_idx[2];
        w_next        = ST_WAIT;
      end
      ST_IDLE: begin
        if (clr_req) w_next = ST_CLEAR;
        else if (w_accept) w_next = (char_data == CHAR_NEWLINE) ? ST_ADDR : ST_SEND;
      end
      ST_SEND: begin
        w_tx_start = 1'b1;
        w_tx_rs    = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_ADDR: begin
        w_tx_start = 1'b1;
        w_tx_byte  = CMD_SET_DDRAM | {1'b0, row_base(r_row, COLS)};
        w_next     = ST_WAIT;
      end
      ST_CLEAR: begin
        w_tx_start = 1'b1;
        w_tx_byte  = CMD_CLEAR;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_tx_done) begin
          case (r_kind)
            K_INIT:  w_next = (r_idx == 3'd7) ? ST_IDLE : ST_INIT;
            K_DATA:  w_next = (w_col_inc == 6'(COLS)) ? ST_ADDR : ST_IDLE;
            default: w_next = ST_IDLE;
          endcase
        end
      end
      default: w_next = ST_PWRUP;
    endcase
  end

  // State register plus cursor, init index, power-up timer and handshake bookkeeping
  always_ff @(posedge CLK_27) begin
    if (RESET) begin
      r_state     <= ST_PWRUP;
      r_kind      <= K_INIT;
      r_pwr_cnt   <= '0;
      r_idx       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_byte      <= '0;
      r_init_done <= 1'b0;
      r_clr_ack   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr_ack <= 1'b0;
      case (r_state)
        ST_PWRUP: if (r_pwr_cnt != '1) r_pwr_cnt <= r_pwr_cnt + 1'b1;
        ST_INIT:  r_kind <= K_INIT;
        ST_SEND:  r_kind <= K_DATA;
        ST_ADDR:  r_kind <= K_ADDR;
        ST_CLEAR: r_kind <= K_CLR;
        ST_IDLE: begin
          if (w_next == ST_SEND) r_byte <= char_data;
          if (w_next == ST_ADDR) begin
            r_col <= '0;
            r_row <= w_next_row;
          end
        end
        ST_WAIT: begin
          if (w_tx_done) begin
            case (r_kind)
              K_INIT: begin
                if (r_idx == 3'd7) r_init_done <= 1'b1;
                else r_idx <= r_idx + 3'd1;
              end
              K_DATA: begin
                if (w_col_inc == 6'(COLS)) begin
                  r_col <= '0;
                  r_row <= w_next_row;
                end else begin
                  r_col <= w_col_inc;
                end
              end
              K_CLR: begin
                r_row     <= '0;
                r_col     <= '0;
                r_clr_ack <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  lcd_nibble_tx #(
    .E_CYC  (E_CYC),
    .NIB_CYC(NIB_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC),
    .PWR_CYC(PWR_CYC)
  ) u_tx (
    .i_clk        (CLK_27),
    .i_reset      (RESET),
    .i_byte       (w_tx_byte),
    .i_rs         (w_tx_rs),
    .i_start      (w_tx_start),
    .i_nibble_only(w_tx_nib_only),
    .i_long_wait  (w_tx_long),
    .o_db         (LCD_FPGA_DB),
    .o_e          (LCD_FPGA_E),
    .o_rs         (LCD_FPGA_RS),
    .o_done       (w_tx_done)
  );

  assign clr_ack     = r_clr_ack;
  assign init_done   = r_init_done;
  assign cur_row     = r_row;
  assign cur_col     = r_col;
  assign LCD_FPGA_RW = 1'b0;

endmodule
